// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard hazard unit for the in-order pipeline.
// It tracks the destination registers of long-latency producers (loads and mul/div)
// from EX issue until writeback.
// It also detects structural hazards on the multi-cycle mul/div unit and stretches
// the mispredict flush over the front-end depth.
// Optional build macro HAZARD_STATS_EN adds two outputs:
//   - stat_stall_cycles: number of cycles with stall asserted
//   - stat_flush_events: number of mispredicts seen
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int XLEN         = 32,
    parameter int MULDIV_LAT   = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                id_valid,
    input  logic [6:0]          id_opcode,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic                id_is_muldiv,
    input  logic                ex_valid,
    input  logic [REG_W-1:0]    ex_rd,
    input  logic                ex_memread,
    input  logic                ex_muldiv,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic                branch,
    input  logic [1:0]          jump,
    input  logic [XLEN-1:0]     predicted_target,
    input  logic [XLEN-1:0]     real_target,
    output logic                stall,
    output logic                flush,
    output logic [NUM_REGS-1:0] sb_pending
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stat_stall_cycles,
    output logic [31:0]         stat_flush_events
`endif
);

    localparam int MD_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT - 1);
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYCLES - 1);

    logic                use_rs1;
    logic                use_rs2;
    logic                long_ex;
    logic [NUM_REGS-1:0] eff_pending;
    logic [NUM_REGS-1:0] sb_next;
    logic                data_hazard;
    logic                struct_hazard;
    logic                mispredict;
    logic                flush_raw;
    logic [MD_W-1:0]     md_cnt;
    logic [FL_W-1:0]     fl_cnt;

    // Decode which source registers the ID instruction actually reads (x0 never hazards)
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = id_valid && (id_rs1 != '0);
                use_rs2 = id_valid && (id_rs2 != '0);
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use_rs1 = id_valid && (id_rs1 != '0);
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    assign long_ex = ex_valid && (ex_memread || ex_muldiv) && (ex_rd != '0);

    // A register being written back this cycle is forwarded, so it no longer blocks ID
    always_comb begin
        eff_pending = sb_pending;
        if (wb_valid) begin
            eff_pending[wb_rd] = 1'b0;
        end
    end

    // Next scoreboard: WB clears, a new long-latency producer sets (set wins on collision)
    always_comb begin
        sb_next = sb_pending;
        if (wb_valid && (wb_rd != '0)) begin
            sb_next[wb_rd] = 1'b0;
        end
        if (long_ex) begin
            sb_next[ex_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Hazard, mispredict and output qualification; reset forces both outputs low
    always_comb begin
        data_hazard   = (use_rs1 && (eff_pending[id_rs1] || (long_ex && (ex_rd == id_rs1)))) ||
                        (use_rs2 && (eff_pending[id_rs2] || (long_ex && (ex_rd == id_rs2))));
        struct_hazard = id_valid && id_is_muldiv && (md_cnt != '0);
        mispredict    = ex_valid && (branch || (jump != 2'b00)) &&
                        (predicted_target != real_target);
        flush_raw     = mispredict || (fl_cnt != '0);
        flush         = rstn && flush_raw;
        stall         = rstn && (data_hazard || struct_hazard) && !flush_raw;
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_pending <= '0;
        end else begin
            sb_pending <= sb_next;
        end
    end

    // Mul/div occupancy: reload on issue, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            md_cnt <= '0;
        end else if (ex_valid && ex_muldiv) begin
            md_cnt <= MD_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    // Flush stretch: every mispredict restarts the remaining flush window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fl_cnt <= '0;
        end else if (mispredict) begin
            fl_cnt <= FL_LOAD;
        end else if (fl_cnt != '0) begin
            fl_cnt <= fl_cnt - FL_W'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    // Free-running statistics, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_stall_cycles <= '0;
            stat_flush_events <= '0;
        end else begin
            if (stall) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (mispredict) begin
                stat_flush_events <= stat_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int NUM_REGS     = 32;
    localparam int REG_W        = 5;
    localparam int XLEN         = 32;
    localparam int MULDIV_LAT   = 4;
    localparam int FLUSH_CYCLES = 3;

    logic                clk = 1'b0;
    logic                rstn;
    logic                id_valid;
    logic [6:0]          id_opcode;
    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic                id_is_muldiv;
    logic                ex_valid;
    logic [REG_W-1:0]    ex_rd;
    logic                ex_memread;
    logic                ex_muldiv;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_rd;
    logic                branch;
    logic [1:0]          jump;
    logic [XLEN-1:0]     predicted_target;
    logic [XLEN-1:0]     real_target;
    logic                stall;
    logic                flush;
    logic [NUM_REGS-1:0] sb_pending;
`ifdef HAZARD_STATS_EN
    logic [31:0]         stat_stall_cycles;
    logic [31:0]         stat_flush_events;
`endif

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .XLEN(XLEN),
        .MULDIV_LAT(MULDIV_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_muldiv(id_is_muldiv),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_muldiv(ex_muldiv),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .branch(branch), .jump(jump),
        .predicted_target(predicted_target), .real_target(real_target),
        .stall(stall), .flush(flush), .sb_pending(sb_pending)
`ifdef HAZARD_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_flush_events(stat_flush_events)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit          pend [NUM_REGS];
    int          md_left;
    int          fl_left;
    int unsigned m_stall_cnt;
    int unsigned m_flush_cnt;
    logic        last_stall;
    logic        last_flush;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 1'b0;
        md_left     = 0;
        fl_left     = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic drive_idle();
        id_valid = 1'b0; id_opcode = 7'd0; id_rs1 = '0; id_rs2 = '0; id_is_muldiv = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_memread = 1'b0; ex_muldiv = 1'b0;
        wb_valid = 1'b0; wb_rd = '0;
        branch = 1'b0; jump = 2'b00; predicted_target = '0; real_target = '0;
    endtask

    function automatic bit eff(input logic [REG_W-1:0] r);
        return pend[r] && !(wb_valid && (wb_rd == r));
    endfunction

    // One clock cycle: compare outputs against the model, then advance the model at the edge
    task automatic tick();
        bit lx, u1, u2, dh, sh, mp, e_fl, e_st;
        logic [NUM_REGS-1:0] e_sb;
        #1;
        lx = ex_valid && (ex_memread || ex_muldiv) && (ex_rd != 0);
        u1 = id_valid && (id_opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR}) && (id_rs1 != 0);
        u2 = id_valid && (id_opcode inside {OP_R, OP_ST, OP_BR}) && (id_rs2 != 0);
        dh = (u1 && (eff(id_rs1) || (lx && ex_rd == id_rs1))) ||
             (u2 && (eff(id_rs2) || (lx && ex_rd == id_rs2)));
        sh = id_valid && id_is_muldiv && (md_left > 0);
        mp = ex_valid && (branch || jump != 0) && (predicted_target != real_target);
        e_fl = mp || (fl_left > 0);
        e_st = (dh || sh) && !e_fl;
        for (int i = 0; i < NUM_REGS; i++) e_sb[i] = pend[i];
        last_stall = stall;
        last_flush = flush;
        chk("stall", 64'(stall), 64'(e_st));
        chk("flush", 64'(flush), 64'(e_fl));
        chk("sb_pending", 64'(sb_pending), 64'(e_sb));
`ifdef HAZARD_STATS_EN
        chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'(m_stall_cnt));
        chk("stat_flush_events", 64'(stat_flush_events), 64'(m_flush_cnt));
`endif
        @(posedge clk);
        if (wb_valid && wb_rd != 0) pend[wb_rd] = 1'b0;
        if (lx) pend[ex_rd] = 1'b1;
        if (ex_valid && ex_muldiv) md_left = MULDIV_LAT - 1;
        else if (md_left > 0) md_left--;
        if (mp) fl_left = FLUSH_CYCLES - 1;
        else if (fl_left > 0) fl_left--;
        if (e_st) m_stall_cnt++;
        if (mp) m_flush_cnt++;
        @(negedge clk);
    endtask

    task automatic set_id(input logic [6:0] op, input int r1, input int r2, input bit md);
        id_valid = 1'b1; id_opcode = op; id_rs1 = REG_W'(r1); id_rs2 = REG_W'(r2); id_is_muldiv = md;
    endtask

    task automatic set_mispredict();
        ex_valid = 1'b1; branch = 1'b1; predicted_target = 32'h100; real_target = 32'h200;
    endtask

    logic [6:0] op_tbl [8];

    initial begin
        op_tbl = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_LUI, OP_JAL};
        model_reset();
        drive_idle();
        rstn = 1'b0;
        last_stall = 1'b0;
        last_flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_flush", 64'(flush), 64'd0);
        chk("reset_sb", 64'(sb_pending), 64'd0);
        rstn = 1'b1;

        // Load x5 followed by a dependent add
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        set_id(OP_R, 5, 1, 1'b0);
        tick();
        chk("tp_load_use_stall", 64'(last_stall), 64'd1);
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        tick();
        chk("tp_pending_stall", 64'(last_stall), 64'd1);
        wb_valid = 1'b1; wb_rd = 5'd5;
        tick();
        chk("tp_wb_forward", 64'(last_stall), 64'd0);
        chk("tp_wb_cleared", 64'(sb_pending[5]), 64'd0);
        drive_idle();

        // x0 reads and lui never stall on a pending x5
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        tick();
        drive_idle();
        set_id(OP_LUI, 5, 5, 1'b0);
        tick();
        chk("tp_lui_no_stall", 64'(last_stall), 64'd0);
        set_id(OP_R, 0, 0, 1'b0);
        tick();
        chk("tp_x0_no_stall", 64'(last_stall), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; id_valid = 1'b0;
        tick();
        drive_idle();

        // Mul/div structural hazard
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_rd = '0;
        tick();
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            set_id(OP_R, 1, 2, 1'b1);
            tick();
            chk("tp_muldiv_busy", 64'(last_stall), (i < 3) ? 64'd1 : 64'd0);
        end
        drive_idle();

        // Flush stretch with a pending hazard in ID
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3;
        tick();
        drive_idle();
        set_id(OP_R, 3, 0, 1'b0);
        set_mispredict();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tp_flush_window", 64'(last_flush), (i < 3) ? 64'd1 : 64'd0);
            chk("tp_flush_stall", 64'(last_stall), (i < 3) ? 64'd0 : 64'd1);
            ex_valid = 1'b0; branch = 1'b0;
        end
        // Back-to-back mispredicts restart the window
        set_mispredict();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tp_flush_restart", 64'(last_flush), (i < 4) ? 64'd1 : 64'd0);
            if (i == 0) set_mispredict();
            else begin ex_valid = 1'b0; branch = 1'b0; end
        end
        drive_idle();
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick();
        drive_idle();

        // Same-edge set and clear: set wins
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7;
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        chk("tp_set_wins", 64'(sb_pending[7]), 64'd1);
        drive_idle();

        // Asynchronous reset mid-hazard
        set_id(OP_R, 7, 0, 1'b0);
        #2;
        chk("pre_reset_stall", 64'(stall), 64'd1);
        rstn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_stall", 64'(stall), 64'd0);
        chk("async_rst_flush", 64'(flush), 64'd0);
        chk("async_rst_sb", 64'(sb_pending), 64'd0);
        set_mispredict();
        #1;
        chk("rst_flush_forced", 64'(flush), 64'd0);
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_opcode    = op_tbl[$urandom_range(0, 7)];
            id_rs1       = REG_W'($urandom_range(0, 7));
            id_rs2       = REG_W'($urandom_range(0, 7));
            id_is_muldiv = ($urandom_range(0, 3) == 0);
            ex_valid     = ($urandom_range(0, 1) == 0);
            ex_rd        = REG_W'($urandom_range(0, 7));
            ex_memread   = ($urandom_range(0, 2) == 0);
            ex_muldiv    = !ex_memread && ($urandom_range(0, 4) == 0);
            wb_valid     = ($urandom_range(0, 1) == 0);
            wb_rd        = REG_W'($urandom_range(0, 7));
            branch       = ($urandom_range(0, 5) == 0);
            jump         = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            predicted_target = $urandom;
            real_target  = ($urandom_range(0, 2) == 0) ? (predicted_target ^ 32'h4) : predicted_target;
            tick();
        end
        drive_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
